// File: rtl/util_mem_pkg.sv
// Shared types and defaults for the util_mem streaming read engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package util_mem_pkg;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_RUN,
        RS_DRAIN
    } rd_state_e;

    localparam int unsigned RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/util_mem_rd_fifo.sv
// Small synchronous FIFO holding SRAM read returns for the output stream.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: caller must not push when full unless popping the same cycle.
module util_mem_rd_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [CNT_W-1:0]  cnt,
    output logic              head_vld,
    output logic [DATA_W-1:0] head_dat
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok   = pop && (cnt != '0);
    assign push_ok  = push && ((cnt != CNT_W'(FIFO_DEPTH)) || pop_ok);
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/util_mem_rd_stream.sv
// Streams cfg_len consecutive SRAM words from cfg_base onto a valid/ready port; host writes share the SRAM port.
// Latency: start sampled -> first out_valid 2 cycles; one word/cycle sustained with out_ready=1 and no host writes.
// Backpressure: reads issued only against free FIFO credits; host writes preempt read issue and are never stalled.
module util_mem_rd_stream
    import util_mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MEM_DEPTH  = 8192,
    parameter int ADDR_W     = $clog2(MEM_DEPTH),
    parameter int FIFO_DEPTH = RD_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    output logic              busy,
    output logic              done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_wen,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [DATA_W-1:0] sram_wmask,
    output logic              sram_ren,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_e         state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   popped;
    logic              inflight;
    logic              done_q;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              pop;
    logic              room;
    logic              rd_issue;

    assign pop = out_valid && out_ready;

    // A pop this cycle frees a slot by the time the new read returns, which keeps
    // the stream at one word per cycle with only two buffer entries.
    assign room = ({1'b0, fifo_cnt} + (CNT_W + 1)'(inflight))
                < ((CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(pop));

    assign rd_issue = (state == RS_RUN) && !wr_req && room;

    assign sram_ren   = rd_issue;
    assign sram_wen   = wr_req;
    assign sram_addr  = wr_req ? wr_addr : rd_addr;
    assign sram_wdata = wr_data;
    assign sram_wmask = '1;

    assign busy = (state != RS_IDLE);
    assign done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RS_IDLE;
            rd_addr  <= '0;
            len_q    <= '0;
            issued   <= '0;
            popped   <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= rd_issue;
            done_q   <= 1'b0;
            if (pop) popped <= popped + (ADDR_W + 1)'(1);
            unique case (state)
                RS_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state   <= RS_RUN;
                            rd_addr <= cfg_base;
                            len_q   <= cfg_len;
                            issued  <= '0;
                            popped  <= '0;
                        end
                    end
                end
                RS_RUN: begin
                    if (rd_issue) begin
                        issued  <= issued + (ADDR_W + 1)'(1);
                        rd_addr <= (rd_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : rd_addr + ADDR_W'(1);
                        if (issued + (ADDR_W + 1)'(1) == len_q) state <= RS_DRAIN;
                    end
                end
                RS_DRAIN: begin
                    if (pop && (popped + (ADDR_W + 1)'(1) == len_q)) begin
                        state  <= RS_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= RS_IDLE;
            endcase
        end
    end

    util_mem_rd_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_dat (sram_rdata),
        .pop      (pop),
        .cnt      (fifo_cnt),
        .head_vld (out_valid),
        .head_dat (out_data)
    );

endmodule

// File: tb/tb_util_mem_rd_stream.sv
// Scoreboard bench for util_mem_rd_stream: 8192-word instance plus a 1296-word instance for address wrap.
module tb_util_mem_rd_stream;

    localparam int DW  = 16;
    localparam int D1  = 8192;
    localparam int AW1 = 13;
    localparam int D2  = 1296;
    localparam int AW2 = 11;
    localparam int FD  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- instance 1 ----------------
    logic           cfg_start = 0;
    logic [AW1-1:0] cfg_base = '0;
    logic [AW1:0]   cfg_len = '0;
    logic           busy, done;
    logic           wr_req = 0;
    logic [AW1-1:0] wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [AW1-1:0] sram_addr;
    logic           sram_wen, sram_ren;
    logic [DW-1:0]  sram_wdata, sram_wmask, sram_rdata;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_ready = 1;

    util_mem_rd_stream #(.DATA_W(DW), .MEM_DEPTH(D1), .ADDR_W(AW1), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .busy(busy), .done(done), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
        .sram_ren(sram_ren), .sram_rdata(sram_rdata), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready)
    );

    logic [DW-1:0] mem1 [D1];
    logic [DW-1:0] shadow [D1];
    always @(posedge clk) begin
        if (sram_wen) mem1[sram_addr] <= sram_wdata;
        if (sram_ren) sram_rdata <= mem1[sram_addr];
    end

    int            exp_addr_q[$];
    logic [DW-1:0] exp_dat_q[$];
    logic          m_busy = 0, done_pend = 0, held_vld = 0;
    logic [DW-1:0] held_dat = '0;
    int            words_left = 0, ren_cnt = 0, pop_cnt = 0;

    always @(negedge clk) begin
        int a;
        int popnow;
        if (!rst_n) begin
            exp_addr_q.delete();
            exp_dat_q.delete();
            m_busy = 0; done_pend = 0; held_vld = 0;
            words_left = 0; ren_cnt = 0; pop_cnt = 0;
        end else begin
            popnow = (out_valid && out_ready) ? 1 : 0;
            chk("done", done, done_pend);
            done_pend = 0;
            chk("busy", busy, m_busy);
            chk("wen", sram_wen, wr_req);
            if (wr_req) begin
                chk("wr_addr", sram_addr, wr_addr);
                chk("wr_noren", sram_ren, 0);
                chk("wmask", sram_wmask, 16'hFFFF);
                shadow[wr_addr] = wr_data;
            end
            if (sram_ren) begin
                ren_cnt++;
                if (exp_addr_q.size() == 0) chk("ren_spurious", 1, 0);
                else begin
                    a = exp_addr_q.pop_front();
                    chk("rd_addr", sram_addr, a);
                    exp_dat_q.push_back(shadow[a]);
                end
                chk("buffered", (ren_cnt - pop_cnt - popnow) <= FD, 1);
            end
            if (held_vld && out_valid) chk("hold", out_data, held_dat);
            held_vld = out_valid && !out_ready;
            held_dat = out_data;
            if (cfg_start && !m_busy) begin
                if (cfg_len == 0) done_pend = 1;
                else begin
                    m_busy = 1;
                    words_left = int'(cfg_len);
                    for (int i = 0; i < int'(cfg_len); i++)
                        exp_addr_q.push_back((int'(cfg_base) + i) % D1);
                end
            end
            if (popnow != 0) begin
                pop_cnt++;
                if (exp_dat_q.size() == 0) chk("pop_spurious", 1, 0);
                else begin
                    chk("data", out_data, exp_dat_q.pop_front());
                    words_left--;
                    if (words_left == 0) begin
                        m_busy = 0;
                        done_pend = 1;
                    end
                end
            end
        end
    end

    // ---------------- instance 2 (non power-of-two depth) ----------------
    logic           cfg_start2 = 0;
    logic [AW2-1:0] cfg_base2 = '0;
    logic [AW2:0]   cfg_len2 = '0;
    logic           busy2, done2;
    logic           wr_req2 = 0;
    logic [AW2-1:0] wr_addr2 = '0;
    logic [DW-1:0]  wr_data2 = '0;
    logic [AW2-1:0] sram_addr2;
    logic           sram_wen2, sram_ren2;
    logic [DW-1:0]  sram_wdata2, sram_wmask2, sram_rdata2;
    logic           out_valid2;
    logic [DW-1:0]  out_data2;
    logic           out_ready2 = 1;

    util_mem_rd_stream #(.DATA_W(DW), .MEM_DEPTH(D2), .ADDR_W(AW2), .FIFO_DEPTH(FD)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start2), .cfg_base(cfg_base2), .cfg_len(cfg_len2),
        .busy(busy2), .done(done2), .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .sram_addr(sram_addr2), .sram_wen(sram_wen2), .sram_wdata(sram_wdata2), .sram_wmask(sram_wmask2),
        .sram_ren(sram_ren2), .sram_rdata(sram_rdata2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready2)
    );

    logic [DW-1:0] mem2 [D2];
    always @(posedge clk) begin
        if (sram_wen2 && int'(sram_addr2) < D2) mem2[sram_addr2] <= sram_wdata2;
        if (sram_ren2) sram_rdata2 <= (int'(sram_addr2) < D2) ? mem2[sram_addr2] : 16'hDEAD;
    end

    int            exp2_addr_q[$];
    logic [DW-1:0] exp2_dat_q[$];
    always @(negedge clk) begin
        int a;
        if (!rst_n) begin
            exp2_addr_q.delete();
            exp2_dat_q.delete();
        end else begin
            if (sram_ren2) begin
                if (exp2_addr_q.size() == 0) chk("t2_ren_spurious", 1, 0);
                else begin
                    a = exp2_addr_q.pop_front();
                    chk("t2_addr", sram_addr2, a);
                    exp2_dat_q.push_back(16'(a * 3 + 7));
                end
            end
            if (out_valid2 && out_ready2) begin
                if (exp2_dat_q.size() == 0) chk("t2_pop_spurious", 1, 0);
                else chk("t2_data", out_data2, exp2_dat_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start(input int base, input int len);
        @(posedge clk); #1;
        cfg_start = 1;
        cfg_base  = AW1'(base);
        cfg_len   = (AW1 + 1)'(len);
        @(posedge clk); #1;
        cfg_start = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (!m_busy && !done_pend && exp_addr_q.size() == 0 && exp_dat_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(tag, ok, 1);
    endtask

    task automatic test_basic();
        start(16'h10, 4);
        // Now one cycle after the edge that sampled the start pulse.
        for (int i = 0; i < 4; i++) begin
            chk("t1_ren", sram_ren, 1);
            chk("t1_valid", out_valid, (i >= 2) ? 1 : 0);
            @(posedge clk); #1;
        end
        chk("t1_ren_end", sram_ren, 0);
        wait_idle("t1_idle", 50);
    endtask

    initial begin
        logic got;
        for (int i = 0; i < D1; i++) begin
            mem1[i]   = 16'(i ^ 32'h5A5A);
            shadow[i] = 16'(i ^ 32'h5A5A);
        end
        for (int i = 0; i < D2; i++) mem2[i] = 16'(i * 3 + 7);

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ren", sram_ren, 0);
        rst_n = 1;

        // 1: basic burst, full throughput
        test_basic();

        // 2: address wrap on a 1296-word memory
        exp2_addr_q.push_back(1294);
        exp2_addr_q.push_back(1295);
        exp2_addr_q.push_back(0);
        exp2_addr_q.push_back(1);
        @(posedge clk); #1;
        cfg_start2 = 1; cfg_base2 = AW2'(1294); cfg_len2 = (AW2 + 1)'(4);
        @(posedge clk); #1;
        cfg_start2 = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done2) begin got = 1; break; end
        end
        chk("t2_done", got, 1);
        chk("t2_addr_left", exp2_addr_q.size(), 0);
        chk("t2_dat_left", exp2_dat_q.size(), 0);

        // 3: consumer toggles ready
        out_ready = 0;
        start(16'h300, 8);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            if (!m_busy && !done_pend && exp_dat_q.size() == 0) break;
        end
        out_ready = 1;
        wait_idle("t3_idle", 50);

        // 4: host write preempts a pending read to the same address
        start(16'h200, 4);
        wr_req = 1; wr_addr = AW1'(16'h202); wr_data = 16'hBEEF;
        #1;
        chk("t4_ren", sram_ren, 0);
        chk("t4_wen", sram_wen, 1);
        @(posedge clk); #1;
        wr_req = 0;
        wait_idle("t4_idle", 50);

        // 5: zero length, then start while busy is ignored
        start(16'h50, 0);
        wait_idle("t5a_idle", 10);
        out_ready = 0;
        start(16'h40, 4);
        repeat (2) @(posedge clk);
        start(16'h100, 3);
        out_ready = 1;
        wait_idle("t5b_idle", 50);

        // 6: reset during drain
        out_ready = 0;
        start(16'h600, 2);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_valid", out_valid, 1);
        rst_n = 0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ren", sram_ren, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        repeat (6) @(posedge clk);
        test_basic();

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
